word_match_engine: RTL and testbench

//  Parametrised successor of the single-word letter checker. Compares decoded Morse characters one at a time

---
 rtl/word_match_pkg.sv | 51 +++++
 rtl/word_rom.sv | 28 ++
 rtl/word_match_engine.sv | 158 +++++++++++++++
 tb/tb_word_match_engine.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_match_pkg.sv
// ============================================================================
// Module   : word_match_pkg
// Brief    : Shared types, ASCII constants and helpers for the word matcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package word_match_pkg;

  typedef enum logic [2:0] {
    WAIT_LETTER = 3'd0,
    FETCH       = 3'd1,
    COMPARE     = 3'd2,
    WORD_DONE   = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  localparam logic [7:0] c_ASCII_LOWER_A   = 8'h61;
  localparam logic [7:0] c_ASCII_LOWER_Z   = 8'h7A;
  localparam logic [7:0] c_ASCII_CASE_DIFF = 8'h20;

  // Each word occupies a power-of-two slot so the address is a plain concat.
  function automatic int addr_stride(input int word_len);
    return 2 ** $clog2(word_len);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= c_ASCII_LOWER_A && c <= c_ASCII_LOWER_Z)
      return c - c_ASCII_CASE_DIFF;
    return c;
  endfunction

  // Built-in word table; the eight entries repeat across the word index space.
  function automatic logic [7:0] rom_char(input int word_idx, input int letter);
    logic [63:0] tbl;
    case (word_idx % 8)
      0:       tbl = "HELLOABC";
      1:       tbl = "WORLDABC";
      2:       tbl = "MORSEABC";
      3:       tbl = "RADIOABC";
      4:       tbl = "SIGNLABC";
      5:       tbl = "QUICKABC";
      6:       tbl = "BRAVOABC";
      default: tbl = "DELTAABC";
    endcase
    return tbl[63 - 8 * letter -: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_rom.sv
// ============================================================================
// Module   : word_rom
// Brief    : Synchronous-read character ROM, one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_rom
  import word_match_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 32,
  parameter int CHAR_W    = 8,
  localparam int IDX_W    = $clog2(WORD_LEN),
  localparam int ADDR_W   = $clog2(NUM_WORDS * addr_stride(WORD_LEN))
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [CHAR_W-1:0] rd_data
);

  always_ff @(posedge clk) begin
    rd_data <= CHAR_W'(rom_char(int'(addr[ADDR_W-1:IDX_W]), int'(addr[IDX_W-1:0])));
  end

endmodule

`default_nettype wire

// File: rtl/word_match_engine.sv
// ============================================================================
// Module   : word_match_engine
// Brief    : Letter-by-letter word matcher with lives, scoring and game over.
//            Optional CASE_FOLD_EN folds 'a'..'z' to upper case before compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_match_engine
  import word_match_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 32,
  parameter int CHAR_W    = 8,
  parameter int PTS_W     = 4,
  parameter int MAX_LIVES = 3,
  localparam int SEL_W    = $clog2(NUM_WORDS),
  localparam int IDX_W    = $clog2(WORD_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                letter_valid,
  input  logic [CHAR_W-1:0]   letter_char,
  output logic                letter_ready,
  input  logic                word_load,
  input  logic [SEL_W-1:0]    word_sel,
  input  logic                game_clear,
  output logic                match,
  output logic                miss,
  output logic [WORD_LEN-1:0] letter_leds,
  output logic [PTS_W-1:0]    points,
  output logic [PTS_W-1:0]    high_score,
  output logic [2:0]          lives,
  output logic                game_over
);

  state_t              r_state, w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic [SEL_W-1:0]    r_word_q;
  logic [CHAR_W-1:0]   r_char_q;
  logic [CHAR_W-1:0]   w_rom_data;
  logic [WORD_LEN-1:0] r_leds;
  logic                r_match, r_miss;
  logic [PTS_W-1:0]    r_points, r_high;
  logic [2:0]          r_lives;
  logic                w_hit, w_last;
  logic                w_do_load, w_quiet, w_capture, w_do_cmp, w_do_done;
  logic                w_ready, w_over;

  word_rom #(
    .WORD_LEN  (WORD_LEN),
    .NUM_WORDS (NUM_WORDS),
    .CHAR_W    (CHAR_W)
  ) u_rom (
    .clk     (clk),
    .addr    ({r_word_q, r_idx}),
    .rd_data (w_rom_data)
  );

`ifdef CASE_FOLD_EN
  assign w_hit = (to_upper(r_char_q[7:0]) == to_upper(w_rom_data[7:0]));
`else
  assign w_hit = (r_char_q == w_rom_data);
`endif
  assign w_last = (r_idx == IDX_W'(WORD_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= WAIT_LETTER;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (game_clear || w_do_load) begin
      w_next_state = WAIT_LETTER;
    end else begin
      case (r_state)
        WAIT_LETTER: if (letter_valid) w_next_state = FETCH;
        FETCH:       w_next_state = COMPARE;
        COMPARE: begin
          if (w_hit)                 w_next_state = w_last ? WORD_DONE : WAIT_LETTER;
          else if (r_lives <= 3'd1)  w_next_state = GAME_OVER;
          else                       w_next_state = WAIT_LETTER;
        end
        WORD_DONE:   w_next_state = WAIT_LETTER;
        GAME_OVER:   w_next_state = GAME_OVER;
        default:     w_next_state = WAIT_LETTER;
      endcase
    end
  end

  // game_clear beats word_load beats letter handling; GAME_OVER ignores loads.
  always_comb begin
    w_do_load = !game_clear && word_load && (r_state != GAME_OVER);
    w_quiet   = !game_clear && !w_do_load;
    w_capture = w_quiet && (r_state == WAIT_LETTER) && letter_valid;
    w_do_cmp  = w_quiet && (r_state == COMPARE);
    w_do_done = w_quiet && (r_state == WORD_DONE);
    w_ready   = (r_state == WAIT_LETTER);
    w_over    = (r_state == GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_word_q <= '0;
      r_char_q <= '0;
      r_leds   <= '0;
      r_match  <= 1'b0;
      r_miss   <= 1'b0;
      r_points <= '0;
      r_high   <= '0;
      r_lives  <= 3'(MAX_LIVES);
    end else begin
      r_match <= 1'b0;
      r_miss  <= 1'b0;
      if (r_points > r_high) r_high <= r_points;
      if (w_capture) r_char_q <= letter_char;
      if (game_clear) begin
        r_points <= '0;
        r_lives  <= 3'(MAX_LIVES);
        r_idx    <= '0;
        r_leds   <= '0;
      end else if (w_do_load) begin
        r_word_q <= word_sel;
        r_idx    <= '0;
        r_leds   <= '0;
      end else if (w_do_cmp) begin
        if (w_hit) begin
          r_leds <= r_leds | (WORD_LEN'(1) << r_idx);
          r_idx  <= r_idx + IDX_W'(1);
        end else begin
          r_miss  <= 1'b1;
          r_idx   <= '0;
          r_leds  <= '0;
          r_lives <= r_lives - 3'd1;
        end
      end else if (w_do_done) begin
        r_match <= 1'b1;
        r_idx   <= '0;
        r_leds  <= '0;
        if (r_points != {PTS_W{1'b1}}) r_points <= r_points + PTS_W'(1);
      end
    end
  end

  assign letter_ready = w_ready;
  assign game_over    = w_over;
  assign match        = r_match;
  assign miss         = r_miss;
  assign letter_leds  = r_leds;
  assign points       = r_points;
  assign high_score   = r_high;
  assign lives        = r_lives;

endmodule

`default_nettype wire

// File: tb/tb_word_match_engine.sv
// ============================================================================
// Module   : tb_word_match_engine
// Brief    : Scoreboard bench for word_match_engine (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_word_match_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       letter_valid = 1'b0;
  logic [7:0] letter_char = 8'h00;
  logic       word_load = 1'b0;
  logic [4:0] word_sel = 5'd0;
  logic       game_clear = 1'b0;
  logic       letter_ready, match, miss, game_over;
  logic [4:0] letter_leds;
  logic [3:0] points, high_score;
  logic [2:0] lives;

  always #5 clk = ~clk;

  word_match_engine u_dut (
    .clk          (clk),
    .rst          (rst),
    .letter_valid (letter_valid),
    .letter_char  (letter_char),
    .letter_ready (letter_ready),
    .word_load    (word_load),
    .word_sel     (word_sel),
    .game_clear   (game_clear),
    .match        (match),
    .miss         (miss),
    .letter_leds  (letter_leds),
    .points       (points),
    .high_score   (high_score),
    .lives        (lives),
    .game_over    (game_over)
  );

  typedef struct {
    logic       exp_miss;
    logic [4:0] exp_leds;
    logic       exp_match;
    logic [3:0] exp_points;
    logic [2:0] exp_lives;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         m_word = 0, m_idx = 0, m_lives = 3, m_points = 0, m_high = 0;
  logic [4:0] m_leds = 5'd0;

  function automatic logic [7:0] tgt(input int w, input int i);
    string s;
    if (w == 5) s = "QUICK";
    else        s = "HELLO";
    return s[i];
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
    return c;
  endfunction

  // Predict the outcome, queue it, then present the letter and wait until
  // edge N+2 has passed so leds/miss are settled.
  task automatic play_letter(input logic [7:0] c);
    exp_t e;
    int   waited;
    waited = 0;
    while (letter_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (letter_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: letter_ready=%b required 1", letter_ready);
    end
    e.exp_match = 1'b0;
    if (fold(c) == fold(tgt(m_word, m_idx))) begin
      m_leds[m_idx] = 1'b1;
      e.exp_miss    = 1'b0;
      e.exp_leds    = m_leds;
      m_idx++;
      if (m_idx == 5) begin
        e.exp_match = 1'b1;
        m_idx  = 0;
        m_leds = 5'd0;
        if (m_points < 15) m_points++;
      end
    end else begin
      e.exp_miss = 1'b1;
      e.exp_leds = 5'd0;
      m_idx  = 0;
      m_leds = 5'd0;
      m_lives--;
    end
    e.exp_points = 4'(m_points);
    e.exp_lives  = 3'(m_lives);
    sb.push_back(e);
    letter_valid = 1'b1;
    letter_char  = c;
    @(posedge clk); #1;
    letter_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    game_clear = 1'b1;
    @(posedge clk); #1;
    game_clear = 1'b0;
    m_points = 0; m_lives = 3; m_idx = 0; m_leds = 5'd0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (letter_ready !== 1'b1 || game_over !== 1'b0 || letter_leds !== 5'd0)
      $display("FAIL reset_ctrl: ready=%b over=%b leds=%b required 1 0 00000", letter_ready, game_over, letter_leds);
    else n_pass++;
    n_checks++;
    if (match !== 1'b0 || miss !== 1'b0 || points !== 4'd0 || high_score !== 4'd0 || lives !== 3'd3)
      $display("FAIL reset_score: match=%b miss=%b points=%0d high=%0d lives=%0d required 0 0 0 0 3",
               match, miss, points, high_score, lives);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_hello();
    string w;
    exp_t  e;
    w = "HELLO";
    for (int i = 0; i < 5; i++) begin
      play_letter(w[i]);
      e = sb.pop_front();
      n_checks++;
      if (miss !== e.exp_miss || letter_leds !== e.exp_leds || lives !== e.exp_lives || match !== 1'b0)
        $display("FAIL hello_letter%0d: miss=%b leds=%b lives=%0d match=%b required %b %b %0d 0",
                 i, miss, letter_leds, lives, match, e.exp_miss, e.exp_leds, e.exp_lives);
      else n_pass++;
      if (e.exp_match) begin
        @(posedge clk); #1;
        n_checks++;
        if (match !== 1'b1 || points !== e.exp_points || high_score !== 4'd0 || letter_leds !== 5'd0)
          $display("FAIL hello_match: match=%b points=%0d high=%0d leds=%b required 1 %0d 0 00000",
                   match, points, high_score, letter_leds, e.exp_points);
        else n_pass++;
        @(posedge clk); #1;
        m_high = m_points;
        n_checks++;
        if (match !== 1'b0 || high_score !== 4'(m_high))
          $display("FAIL hello_high_lag: match=%b high=%0d required 0 %0d", match, high_score, m_high);
        else n_pass++;
      end
    end
  endtask

  task automatic test_miss_recover();
    string w;
    exp_t  e;
    w = "HEXHELLO";
    do_clear();
    for (int i = 0; i < 8; i++) begin
      play_letter(w[i]);
      e = sb.pop_front();
      n_checks++;
      if (miss !== e.exp_miss || letter_leds !== e.exp_leds || lives !== e.exp_lives)
        $display("FAIL miss_letter%0d: miss=%b leds=%b lives=%0d required %b %b %0d",
                 i, miss, letter_leds, lives, e.exp_miss, e.exp_leds, e.exp_lives);
      else n_pass++;
      if (e.exp_match) begin
        @(posedge clk); #1;
        n_checks++;
        if (match !== 1'b1 || points !== e.exp_points || lives !== 3'd2)
          $display("FAIL miss_then_match: match=%b points=%0d lives=%0d required 1 %0d 2",
                   match, points, lives, e.exp_points);
        else n_pass++;
      end
    end
  endtask

  task automatic test_game_over();
    exp_t e;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      play_letter("Z");
      e = sb.pop_front();
      n_checks++;
      if (miss !== e.exp_miss || lives !== e.exp_lives)
        $display("FAIL over_miss%0d: miss=%b lives=%0d required %b %0d", i, miss, lives, e.exp_miss, e.exp_lives);
      else n_pass++;
    end
    n_checks++;
    if (game_over !== 1'b1 || letter_ready !== 1'b0 || lives !== 3'd0)
      $display("FAIL over_state: over=%b ready=%b lives=%0d required 1 0 0", game_over, letter_ready, lives);
    else n_pass++;
    letter_valid = 1'b1; letter_char = "H"; word_load = 1'b1; word_sel = 5'd5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (game_over !== 1'b1 || miss !== 1'b0 || letter_leds !== 5'd0 || lives !== 3'd0)
        $display("FAIL over_ignore%0d: over=%b miss=%b leds=%b lives=%0d required 1 0 00000 0",
                 i, game_over, miss, letter_leds, lives);
      else n_pass++;
    end
    letter_valid = 1'b0; word_load = 1'b0;
    do_clear();
    n_checks++;
    if (game_over !== 1'b0 || letter_ready !== 1'b1 || lives !== 3'd3 || points !== 4'd0 || high_score !== 4'(m_high))
      $display("FAIL over_clear: over=%b ready=%b lives=%0d points=%0d high=%0d required 0 1 3 0 %0d",
               game_over, letter_ready, lives, points, high_score, m_high);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    string w;
    exp_t  e;
    letter_valid = 1'b1; letter_char = "H"; word_load = 1'b1; word_sel = 5'd5;
    @(posedge clk); #1;
    letter_valid = 1'b0; word_load = 1'b0;
    m_word = 5; m_idx = 0; m_leds = 5'd0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (letter_ready !== 1'b1 || miss !== 1'b0 || letter_leds !== 5'd0)
        $display("FAIL load_drop%0d: ready=%b miss=%b leds=%b required 1 0 00000", i, letter_ready, miss, letter_leds);
      else n_pass++;
      @(posedge clk); #1;
    end
    // A wrong letter whose compare is overtaken by a load must not cost a life.
    letter_valid = 1'b1; letter_char = "Z";
    @(posedge clk); #1;
    letter_valid = 1'b0; word_load = 1'b1; word_sel = 5'd5;
    @(posedge clk); #1;
    word_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (miss !== 1'b0 || lives !== 3'd3 || letter_ready !== 1'b1)
        $display("FAIL load_discard%0d: miss=%b lives=%0d ready=%b required 0 3 1", i, miss, lives, letter_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    w = "QUICK";
    for (int i = 0; i < 5; i++) begin
      play_letter(w[i]);
      e = sb.pop_front();
      n_checks++;
      if (miss !== e.exp_miss || letter_leds !== e.exp_leds)
        $display("FAIL load_letter%0d: miss=%b leds=%b required %b %b", i, miss, letter_leds, e.exp_miss, e.exp_leds);
      else n_pass++;
      if (e.exp_match) begin
        @(posedge clk); #1;
        n_checks++;
        if (match !== 1'b1 || points !== e.exp_points)
          $display("FAIL load_match: match=%b points=%0d required 1 %0d", match, points, e.exp_points);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturate();
    string w;
    exp_t  e;
    w = "QUICK";
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 5; i++) begin
        play_letter(w[i]);
        e = sb.pop_front();
        n_checks++;
        if (miss !== e.exp_miss || letter_leds !== e.exp_leds)
          $display("FAIL sat_w%0d_l%0d: miss=%b leds=%b required %b %b", k, i, miss, letter_leds, e.exp_miss, e.exp_leds);
        else n_pass++;
        if (e.exp_match) begin
          @(posedge clk); #1;
          n_checks++;
          if (match !== 1'b1 || points !== e.exp_points)
            $display("FAIL sat_match%0d: match=%b points=%0d required 1 %0d", k, match, points, e.exp_points);
          else n_pass++;
        end
      end
    end
    @(posedge clk); #1;
    m_high = m_points;
    n_checks++;
    if (points !== 4'd15 || high_score !== 4'(m_high))
      $display("FAIL sat_final: points=%0d high=%0d required 15 %0d", points, high_score, m_high);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    play_letter("Q");
    e = sb.pop_front();
    n_checks++;
    if (letter_leds !== e.exp_leds || miss !== e.exp_miss)
      $display("FAIL arst_pre: leds=%b miss=%b required %b %b", letter_leds, miss, e.exp_leds, e.exp_miss);
    else n_pass++;
    letter_valid = 1'b1; letter_char = "Z";
    @(posedge clk); #1;
    letter_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (letter_leds !== 5'd0 || points !== 4'd0 || high_score !== 4'd0 || lives !== 3'd3 ||
        letter_ready !== 1'b1 || game_over !== 1'b0 || match !== 1'b0 || miss !== 1'b0)
      $display("FAIL arst_now: leds=%b points=%0d high=%0d lives=%0d ready=%b over=%b match=%b miss=%b required reset values",
               letter_leds, points, high_score, lives, letter_ready, game_over, match, miss);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    m_word = 0; m_idx = 0; m_leds = 5'd0; m_lives = 3; m_points = 0; m_high = 0;
    @(posedge clk); #1;
    n_checks++;
    if (miss !== 1'b0 || letter_leds !== 5'd0 || lives !== 3'd3)
      $display("FAIL arst_after: miss=%b leds=%b lives=%0d required 0 00000 3", miss, letter_leds, lives);
    else n_pass++;
  endtask

  task automatic test_case_fold();
    exp_t e;
    string w;
    w = "hello";
    play_letter(w[0]);
    e = sb.pop_front();
    n_checks++;
    if (miss !== e.exp_miss || letter_leds !== e.exp_leds || lives !== e.exp_lives)
      $display("FAIL case_h: miss=%b leds=%b lives=%0d required %b %b %0d",
               miss, letter_leds, lives, e.exp_miss, e.exp_leds, e.exp_lives);
    else n_pass++;
`ifdef CASE_FOLD_EN
    for (int i = 1; i < 5; i++) begin
      play_letter(w[i]);
      e = sb.pop_front();
      n_checks++;
      if (miss !== e.exp_miss || letter_leds !== e.exp_leds)
        $display("FAIL case_l%0d: miss=%b leds=%b required %b %b", i, miss, letter_leds, e.exp_miss, e.exp_leds);
      else n_pass++;
      if (e.exp_match) begin
        @(posedge clk); #1;
        n_checks++;
        if (match !== 1'b1 || points !== e.exp_points)
          $display("FAIL case_match: match=%b points=%0d required 1 %0d", match, points, e.exp_points);
        else n_pass++;
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hello();
    test_miss_recover();
    test_game_over();
    test_load_priority();
    test_saturate();
    test_async_reset();
    test_case_fold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule

`default_nettype wire
